// File: rtl/store_buffer.sv
// Posted-write store buffer: in-order drain to memory through a ready handshake,
// with youngest-first load forwarding. Optional in-place merging of repeated
// stores to the youngest entry is enabled by defining STORE_BUFFER_COALESCE_EN.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     MemWriteM,
    input  logic [31:0]              DataAdr,
    input  logic [31:0]              WriteData,
    output logic                     StallM,
    input  logic [31:0]              LdAdr,
    output logic                     LdHit,
    output logic [31:0]              LdData,
    output logic                     MemWe,
    output logic [31:0]              MemAdr,
    output logic [31:0]              MemWd,
    input  logic                     MemReady,
    output logic                     Empty,
    output logic [$clog2(DEPTH):0]   Count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]      adr_q  [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;

    logic [PTR_W-1:0] youngest;
    logic             full;
    logic             coalesce;
    logic             pop;
    logic             alloc;
    logic [PTR_W-1:0] fwd_idx;
    logic             unused_ld_bits;

    assign youngest = tail_q - PTR_W'(1);
    assign full     = (count_q == CNT_W'(DEPTH));

`ifdef STORE_BUFFER_COALESCE_EN
    // Requiring two entries keeps the head (possibly on the bus) untouched.
    assign coalesce = MemWriteM && (count_q >= CNT_W'(2)) &&
                      (DataAdr[31:2] == adr_q[youngest][31:2]);
`else
    assign coalesce = 1'b0;
`endif

    assign MemWe  = valid_q[head_q];
    assign MemAdr = adr_q[head_q];
    assign MemWd  = data_q[head_q];
    assign pop    = MemWe && MemReady;
    assign StallM = MemWriteM && full && !MemReady && !coalesce;
    assign alloc  = MemWriteM && !StallM && !coalesce;
    assign Empty  = (count_q == '0);
    assign Count  = count_q;

    assign unused_ld_bits = ^LdAdr[1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                adr_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PTR_W'(1);
            end
            // When full and popping, tail == head; the allocation must win.
            if (alloc) begin
                adr_q[tail_q]   <= DataAdr;
                data_q[tail_q]  <= WriteData;
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + PTR_W'(1);
            end
            if (coalesce) begin
                adr_q[youngest]  <= DataAdr;
                data_q[youngest] <= WriteData;
            end
            case ({alloc, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Walk back from tail-1; the first valid match is the youngest.
    always_comb begin
        LdHit   = 1'b0;
        LdData  = '0;
        fwd_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = tail_q - PTR_W'(i + 1);
            if (!LdHit && valid_q[fwd_idx] &&
                (adr_q[fwd_idx][31:2] == LdAdr[31:2])) begin
                LdHit  = 1'b1;
                LdData = data_q[fwd_idx];
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: scoreboard of accepted stores compared
// against the memory-side drain, plus reset, stall, forwarding and wrap scenarios.
module tb_store_buffer;

    logic        clk;
    logic        reset;
    logic        MemWriteM;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic        StallM;
    logic [31:0] LdAdr;
    logic        LdHit;
    logic [31:0] LdData;
    logic        MemWe;
    logic [31:0] MemAdr;
    logic [31:0] MemWd;
    logic        MemReady;
    logic        Empty;
    logic [2:0]  Count;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    ent_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    logic        hold_vld;
    logic [31:0] hold_adr;
    logic [31:0] hold_wd;

    store_buffer #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset), .MemWriteM(MemWriteM), .DataAdr(DataAdr),
        .WriteData(WriteData), .StallM(StallM), .LdAdr(LdAdr), .LdHit(LdHit),
        .LdData(LdData), .MemWe(MemWe), .MemAdr(MemAdr), .MemWd(MemWd),
        .MemReady(MemReady), .Empty(Empty), .Count(Count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory-side monitor: every write retired at the next edge must match the scoreboard head.
    always @(negedge clk) begin
        if (reset) begin
            hold_vld <= 1'b0;
        end else begin
            if (hold_vld) begin
                total = total + 1;
                if (MemAdr !== hold_adr || MemWd !== hold_wd) begin
                    bad = bad + 1;
                    $display("FAIL hold_stable: got %h/%h want %h/%h", MemAdr, MemWd, hold_adr, hold_wd);
                end
            end
            if (MemWe && MemReady) begin
                total = total + 1;
                if (sb_q.size() == 0) begin
                    bad = bad + 1;
                    $display("FAIL drain_unexpected: got %h/%h want none", MemAdr, MemWd);
                end else begin
                    if (MemAdr !== sb_q[0].a || MemWd !== sb_q[0].d) begin
                        bad = bad + 1;
                        $display("FAIL drain_order: got %h/%h want %h/%h", MemAdr, MemWd, sb_q[0].a, sb_q[0].d);
                    end
                    void'(sb_q.pop_front());
                end
            end
            hold_vld <= MemWe && !MemReady;
            hold_adr <= MemAdr;
            hold_wd  <= MemWd;
        end
    end

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        int n  = 0;
        bit ok = 0;
        MemWriteM = 1'b1;
        DataAdr   = a;
        WriteData = d;
        while (!ok && n < 50) begin
            @(negedge clk);
            if (!StallM) begin
                ok = 1;
                sb_q.push_back({a, d});
            end
            @(posedge clk);
            #1;
            n++;
        end
        MemWriteM = 1'b0;
        if (!ok) begin
            total = total + 1;
            bad   = bad + 1;
            $display("FAIL store_timeout: addr %h still stalled, want accepted", a);
        end
    endtask

    task automatic drain();
        int n = 0;
        MemReady = 1'b1;
        while (!Empty && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        total = total + 1;
        if (!Empty) begin
            bad = bad + 1;
            $display("FAIL drain_timeout: Empty=%b want 1", Empty);
        end
        total = total + 1;
        if (sb_q.size() != 0) begin
            bad = bad + 1;
            $display("FAIL sb_leftover: %0d entries pending want 0", sb_q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; MemWriteM = 1'b0; DataAdr = '0; WriteData = '0;
        LdAdr = '0; MemReady = 1'b0;
        #12;
        total = total + 1;
        if ({StallM, MemWe, Empty, Count, LdHit} !== 7'b0010000 || LdData !== 32'd0) begin
            bad = bad + 1;
            $display("FAIL reset_values: stall=%b we=%b empty=%b count=%0d hit=%b data=%h want 0,0,1,0,0,0",
                     StallM, MemWe, Empty, Count, LdHit, LdData);
        end
        #10;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        MemReady = 1'b1;
        store(32'd100, 32'd7);
        total = total + 1;
        if (MemWe !== 1'b1 || MemAdr !== 32'd100 || MemWd !== 32'd7) begin
            bad = bad + 1;
            $display("FAIL single_offer: we=%b adr=%0d wd=%0d want 1,100,7", MemWe, MemAdr, MemWd);
        end
        @(posedge clk);
        #1;
        total = total + 1;
        if (Empty !== 1'b1) begin
            bad = bad + 1;
            $display("FAIL single_empty: Empty=%b want 1", Empty);
        end
    endtask

    task automatic test_full_stall();
        MemReady = 1'b0;
        for (int k = 0; k < 4; k++) store(32'd96 + 32'(4 * k), 32'(k + 1));
        total = total + 1;
        if (Count !== 3'd4) begin
            bad = bad + 1;
            $display("FAIL full_count: Count=%0d want 4", Count);
        end
        MemWriteM = 1'b1; DataAdr = 32'd112; WriteData = 32'd5;
        @(negedge clk);
        total = total + 1;
        if (StallM !== 1'b1) begin
            bad = bad + 1;
            $display("FAIL full_stall: StallM=%b want 1", StallM);
        end
        @(posedge clk);
        #1;
        MemReady = 1'b1;
        @(negedge clk);
        total = total + 1;
        if (StallM !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL full_accept: StallM=%b want 0", StallM);
        end
        sb_q.push_back({32'd112, 32'd5});
        @(posedge clk);
        #1;
        MemWriteM = 1'b0;
        total = total + 1;
        if (Count !== 3'd4) begin
            bad = bad + 1;
            $display("FAIL full_pushpop_count: Count=%0d want 4", Count);
        end
        drain();
    endtask

    task automatic test_forward();
        MemReady = 1'b0;
        store(32'd100, 32'd5);
        store(32'd100, 32'd7);
        LdAdr = 32'd102;
        #1;
        total = total + 1;
        if (LdHit !== 1'b1 || LdData !== 32'd7) begin
            bad = bad + 1;
            $display("FAIL fwd_youngest: hit=%b data=%0d want 1,7", LdHit, LdData);
        end
        LdAdr = 32'd200;
        #1;
        total = total + 1;
        if (LdHit !== 1'b0 || LdData !== 32'd0) begin
            bad = bad + 1;
            $display("FAIL fwd_miss: hit=%b data=%0d want 0,0", LdHit, LdData);
        end
        // A store arriving this cycle must not be visible to the lookup.
        LdAdr = 32'd300; MemWriteM = 1'b1; DataAdr = 32'd300; WriteData = 32'd11;
        #1;
        total = total + 1;
        if (LdHit !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL fwd_incoming: hit=%b want 0", LdHit);
        end
        @(negedge clk);
        sb_q.push_back({32'd300, 32'd11});
        @(posedge clk);
        #1;
        MemWriteM = 1'b0;
        total = total + 1;
        if (LdHit !== 1'b1 || LdData !== 32'd11) begin
            bad = bad + 1;
            $display("FAIL fwd_after_push: hit=%b data=%0d want 1,11", LdHit, LdData);
        end
        LdAdr = 32'd100;
        MemReady = 1'b1;
        @(posedge clk);
        #1;
        total = total + 1;
        if (LdHit !== 1'b1 || LdData !== 32'd7) begin
            bad = bad + 1;
            $display("FAIL fwd_popping: hit=%b data=%0d want 1,7", LdHit, LdData);
        end
        @(posedge clk);
        #1;
        total = total + 1;
        if (LdHit !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL fwd_retired: hit=%b want 0", LdHit);
        end
        drain();
    endtask

`ifdef STORE_BUFFER_COALESCE_EN
    task automatic test_coalesce();
        MemReady = 1'b0;
        store(32'd96, 32'd1);
        store(32'd100, 32'd5);
        store(32'd100, 32'd7);
        total = total + 1;
        if (Count !== 3'd2) begin
            bad = bad + 1;
            $display("FAIL coalesce_count: Count=%0d want 2", Count);
        end
        sb_q.delete();
        sb_q.push_back({32'd96, 32'd1});
        sb_q.push_back({32'd100, 32'd7});
        drain();
    endtask
`endif

    task automatic test_back_to_back();
        logic [31:0] d;
        MemReady = 1'b1;
        for (int i = 0; i < 8; i++) begin
            d = $urandom;
            MemWriteM = 1'b1; DataAdr = 32'd400 + 32'(4 * i); WriteData = d;
            @(negedge clk);
            total = total + 1;
            if (StallM !== 1'b0 || Count !== ((i == 0) ? 3'd0 : 3'd1)) begin
                bad = bad + 1;
                $display("FAIL b2b_flow[%0d]: stall=%b count=%0d want 0,%0d", i, StallM, Count, (i == 0) ? 0 : 1);
            end
            sb_q.push_back({32'd400 + 32'(4 * i), d});
            @(posedge clk);
            #1;
        end
        MemWriteM = 1'b0;
        drain();
    endtask

    task automatic test_wrap();
        for (int r = 0; r < 3; r++) begin
            MemReady = 1'b0;
            for (int k = 0; k < 4; k++) store(32'd1000 + 32'(64 * r + 4 * k), $urandom);
            total = total + 1;
            if (Count !== 3'd4) begin
                bad = bad + 1;
                $display("FAIL wrap_fill[%0d]: Count=%0d want 4", r, Count);
            end
            drain();
        end
    endtask

    task automatic test_reset_mid();
        MemReady = 1'b0;
        for (int k = 0; k < 3; k++) store(32'd500 + 32'(4 * k), 32'(k + 20));
        total = total + 1;
        if (Count !== 3'd3) begin
            bad = bad + 1;
            $display("FAIL mid_count: Count=%0d want 3", Count);
        end
        MemReady = 1'b1;
        sb_q.delete();
        #1;
        reset = 1'b1;
        #1;
        total = total + 1;
        if (Count !== 3'd0 || MemWe !== 1'b0 || Empty !== 1'b1) begin
            bad = bad + 1;
            $display("FAIL mid_reset: count=%0d we=%b empty=%b want 0,0,1", Count, MemWe, Empty);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        total = total + 1;
        if (MemWe !== 1'b0 || Empty !== 1'b1) begin
            bad = bad + 1;
            $display("FAIL mid_after: we=%b empty=%b want 0,1", MemWe, Empty);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_full_stall();
        test_forward();
`ifdef STORE_BUFFER_COALESCE_EN
        test_coalesce();
`endif
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
